// File: rtl/vote_pkg.sv
// Shared types and sizing for the vote tally / winner-scan controller.
package vote_pkg;

    localparam int unsigned N_CAND_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 21;

    typedef enum logic [1:0] {
        OPEN = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for n candidates; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vote_scan_ctrl_if.sv
// Vote request/grant, poll control and result readout bundle for vote_scan_ctrl.
interface vote_scan_ctrl_if #(
    parameter int unsigned N_CAND = vote_pkg::N_CAND_DEF,
    parameter int unsigned CNT_W  = vote_pkg::CNT_W_DEF
);
    localparam int unsigned IDX_W = vote_pkg::idx_w(N_CAND);

    logic [N_CAND-1:0] vote_req;
    logic [N_CAND-1:0] vote_gnt;
    logic              close_poll;
    logic              clear;
    logic              busy;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [CNT_W-1:0]  win_count;
    logic              tie;
    logic [IDX_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  rd_data;

    modport master (
        output vote_req, close_poll, clear, rd_sel,
        input  vote_gnt, busy, win_valid, win_idx, win_count, tie, rd_data
    );

    modport slave (
        input  vote_req, close_poll, clear, rd_sel,
        output vote_gnt, busy, win_valid, win_idx, win_count, tie, rd_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr with wrap.
module rr_arbiter
    import vote_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] next_ptr
);

    logic [W-1:0] sel;
    logic         found;

    // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (W'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                sel    = W'(i);
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                sel    = W'(i);
                found  = 1'b1;
            end
        end
        if (!found) begin
            next_ptr = ptr;
        end else if (sel == W'(N - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = sel + W'(1);
        end
    end

endmodule

// File: rtl/vote_scan_ctrl.sv
// Vote tally controller: round-robin vote counting, then a sequential max-scan for the winner.
// Define TIE_DETECT_EN to build the tie-detection compare; otherwise tie is constant 0.
module vote_scan_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned N_CAND = N_CAND_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input logic             clk,
    input logic             rst,
    vote_scan_ctrl_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_w(N_CAND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt [N_CAND];
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  arb_next;
    logic [N_CAND-1:0] arb_gnt;
    logic [N_CAND-1:0] gnt;
    logic              vote_en;
    logic [IDX_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]  best_idx;
    logic [CNT_W-1:0]  best_cnt;
    logic              best_tie;
    logic              busy;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [CNT_W-1:0]  win_count;
    logic              win_tie;
    logic [CNT_W-1:0]  rd_mux;

    rr_arbiter #(.N(N_CAND)) u_arb (
        .req      (bus.vote_req),
        .ptr      (rr_ptr),
        .gnt      (arb_gnt),
        .next_ptr (arb_next)
    );

    // Grants only while voting is open and neither clear nor close_poll claims the cycle.
    assign vote_en  = rst && (state == OPEN) && !bus.clear && !bus.close_poll;
    assign gnt      = vote_en ? arb_gnt : '0;
    assign scan_cnt = cnt[scan_idx];

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (bus.rd_sel == IDX_W'(i)) rd_mux = cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= OPEN;
            rr_ptr    <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            best_tie  <= 1'b0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            win_idx   <= '0;
            win_count <= '0;
            win_tie   <= 1'b0;
            for (int unsigned i = 0; i < N_CAND; i++) cnt[i] <= '0;
        end else if (bus.clear) begin
            state     <= OPEN;
            rr_ptr    <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            best_tie  <= 1'b0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            win_idx   <= '0;
            win_count <= '0;
            win_tie   <= 1'b0;
            for (int unsigned i = 0; i < N_CAND; i++) cnt[i] <= '0;
        end else begin
            case (state)
                OPEN: begin
                    if (bus.close_poll) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                        busy     <= 1'b1;
                    end else if (|gnt) begin
                        rr_ptr <= arb_next;
                        // A saturated candidate still receives its grant; the vote is dropped.
                        for (int unsigned i = 0; i < N_CAND; i++) begin
                            if (gnt[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    if (scan_idx == '0) begin
                        best_cnt <= scan_cnt;
                        best_idx <= '0;
                        best_tie <= 1'b0;
                    end else if (scan_cnt > best_cnt) begin
                        best_cnt <= scan_cnt;
                        best_idx <= scan_idx;
                        best_tie <= 1'b0;
                    end
`ifdef TIE_DETECT_EN
                    else if (scan_cnt == best_cnt) begin
                        best_tie <= 1'b1;
                    end
`endif
                    if (scan_idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Publish once the final compare has settled; results then hold.
                    if (!win_valid) begin
                        win_valid <= 1'b1;
                        win_idx   <= best_idx;
                        win_count <= best_cnt;
                        win_tie   <= best_tie;
                    end
                end
                default: state <= OPEN;
            endcase
        end
    end

    assign bus.vote_gnt  = gnt;
    assign bus.busy      = busy;
    assign bus.win_valid = win_valid;
    assign bus.win_idx   = win_idx;
    assign bus.win_count = win_count;
    assign bus.tie       = win_tie;
    assign bus.rd_data   = rd_mux;

endmodule

// File: doc/vote_scan_ctrl.md
Name: vote_scan_ctrl

Overview:
Controller for the candidate vote tally and winner selection.
- Shares one tally-update path among N_CAND vote requesters using a round-robin arbiter.
- Holds one saturating counter per candidate.
- On poll close, scans the counters sequentially, one compare per cycle, to produce the winner index, winning count and a tie flag.
- Sits between debounced vote inputs and the result display/readout logic.

Parameters:
N_CAND, 4, number of candidates/requesters (≥2)
CNT_W, 21, width of each vote counter
IDX_W, $clog2(N_CAND), candidate index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
vote_req  in  N_CAND  per-candidate vote request; held high until granted
vote_gnt  out  N_CAND  one-hot grant, combinational; vote counted at the edge where req&gnt
close_poll  in  1  single-cycle pulse, ends voting and starts the scan
clear  in  1  synchronous clear of tallies and results, any state
busy  out  1  high while scanning
win_valid  out  1  result outputs valid
win_idx  out  IDX_W  winning candidate index
win_count  out  CNT_W  winning vote count
tie  out  1  another candidate equals win_count
rd_sel  in  IDX_W  tally readout select
rd_data  out  CNT_W  count[rd_sel], combinational; 0 if rd_sel ≥ N_CAND

Behaviour:
- Reset (rst=0, async): state=OPEN, all counts=0, rr pointer=0, scan index=0, best=0, win_valid=0, win_idx=0, win_count=0, tie=0, busy=0, vote_gnt=0.

- States: OPEN, SCAN, DONE.

- OPEN:
  - vote_gnt one-hot among asserted vote_req.
  - Priority starts at the rr pointer and wraps upward.
  - After a grant, the pointer = granted index+1, mod N_CAND.
  - The granted counter increments at the clock edge and saturates at all-ones. A saturated grant is still issued and the vote is dropped.
  - At most one vote per cycle.

- close_poll in OPEN:
  - vote_gnt forced 0 that cycle; no vote counted.
  - Next state SCAN, scan index=0.
  - Ignored in SCAN/DONE.

- SCAN (busy=1, vote_gnt=0):
  - Index 0 loads best=count[0], best_idx=0, tie=0.
  - Index i>0:
    - count[i] > best → replace best and best_idx, clear tie.
    - count[i] == best → set tie.
    - Lowest index wins ties.
  - After index N_CAND-1, go to DONE.

- Latency: close_poll sampled at edge t → SCAN for N_CAND cycles → win_valid high from edge t+N_CAND+1.

- DONE:
  - win_valid=1; win_idx, win_count and tie hold.
  - vote_req ignored; vote_gnt=0.
  - Counters frozen and readable via rd_sel.

- clear (any state, highest priority over close_poll and votes):
  - Next edge: counts=0, state=OPEN, pointer=0, win_valid=0, busy=0, result outputs=0.
  - clear mid-SCAN aborts the scan; no partial result is published.

- All-zero tallies: win_idx=0, win_count=0, tie=1.

- rst deassertion mid-operation restarts cleanly in OPEN; no state is retained.

Optional Feature:
TIE_DETECT_EN.
- Defined: tie computed as above.
- Undefined: tie tied to 0, equality compare logic removed; lowest-index-wins ordering unchanged.

Decomposition:
- Package vote_pkg:
  - state enum {OPEN, SCAN, DONE}
  - default N_CAND, CNT_W
  - IDX_W helper
- Sub-module rr_arbiter (params N: req, pointer → one-hot gnt, next pointer); instantiated once.
- Counters, scan FSM and compare logic stay in vote_scan_ctrl.

Test Plan:
1. Reset, then vote_req=4'b1111 held 8 cycles → grant order 0,1,2,3,0,1,2,3; counts all 2.
2. Votes 5,9,3,7 (cand 0..3), close_poll → busy for 4 cycles; win_valid 5 cycles after close_poll edge; win_idx=1, win_count=9, tie=0.
3. Votes 6,6,2,6, close → win_idx=0, win_count=6, tie=1 (tie=0 without TIE_DETECT_EN).
4. close_poll and vote_req[2] in the same cycle → no grant; count[2] unchanged; scan starts.
5. Preload count[3] to 2^21-1 via votes (or force), vote cand 3 → count holds at all-ones; gnt still pulses.
6. clear asserted during scan cycle 2 → next cycle OPEN, counts 0, win_valid=0; rst low mid-DONE → all outputs 0 immediately (async).
